// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-add unsigned w x w -> 2w multiplier on a ripple-carry adder
// Optional early termination when the remaining multiplier bits are zero: define MUL_EARLY_TERM_EN.

module ripple_carry_adder #(
  parameter int w = 8
) (
  input  logic [w-1:0] x,
  input  logic [w-1:0] y,
  input  logic         ci,
  output logic [w-1:0] s
);

  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < w; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
  end

endmodule

module shift_add_multiplier #(
  parameter int w = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [w-1:0]   a,
  input  logic [w-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*w-1:0] product
);

  localparam int CW = $clog2(w + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [w-1:0]    m;
  logic [w-1:0]    q;
  logic [w-1:0]    acc;
  logic [CW-1:0]   cnt;
  logic [w:0]      s;
  logic [w:0]      t;
  logic [w-1:0]    acc_step;
  logic [w-1:0]    q_step;
  logic            finish;
  logic [2*w-1:0]  result;

  // Zero-extended operands keep the carry in s[w], since the adder has no carry-out.
  ripple_carry_adder #(.w(w + 1)) u_adder (
    .x  ({1'b0, acc}),
    .y  ({1'b0, m}),
    .ci (1'b0),
    .s  (s)
  );

  always_comb begin
    t        = q[0] ? s : {1'b0, acc};
    acc_step = t[w:1];
    q_step   = {t[0], q[w-1:1]};
`ifdef MUL_EARLY_TERM_EN
    begin
      logic [w-1:0] remaining;
      remaining = (q >> 1) & ~({w{1'b1}} << (cnt - CW'(1)));
      finish    = (cnt == CW'(1)) || (remaining == '0);
      // Apply the skipped shifts in one step so the result matches the full-length path.
      result    = {acc_step, q_step} >> (cnt - CW'(1));
    end
`else
    finish = (cnt == CW'(1));
    result = {acc_step, q_step};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= a;
            q   <= b;
            acc <= '0;
            cnt <= CW'(w);
          end
        end
        RUN: begin
          acc <= acc_step;
          q   <= q_step;
          cnt <= cnt - CW'(1);
          if (finish) product <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - randomized self-checking bench for shift_add_multiplier

module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  shift_add_multiplier #(.w(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic int model_latency(input logic [W-1:0] bb);
`ifdef MUL_EARLY_TERM_EN
    int p;
    p = -1;
    for (int i = 0; i < W; i++) if (bb[i]) p = i;
    return (p + 1 < 1) ? 1 : p + 1;
`else
    return W;
`endif
  endfunction

  // Drives one operation from a first-IDLE-cycle position; returns one cycle after done.
  // inject_at >= 0 pulses a stray start (a=100,b=100) after that many cycles of RUN.
  task automatic run_mul(input logic [W-1:0] aa, input logic [W-1:0] bb, input int inject_at,
                         output int lat, output logic [2*W-1:0] p, output bit busy_ok,
                         output bit timed_out, output logic done_after);
    start = 1'b1; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_ok = 1'b1; timed_out = 1'b0;
    while (done !== 1'b1) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (lat == inject_at) begin
        start = 1'b1; a = 8'd100; b = 8'd100;
      end else begin
        start = 1'b0; a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (lat > 40) begin
        timed_out = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    p = product;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b product=%0d, want 0 0 0", busy, done, product);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [5] = '{8'd13, 8'd255, 8'd0, 8'd9, 8'd77};
    logic [W-1:0] tbv[5] = '{8'd11, 8'd255, 8'd200, 8'h10, 8'h80};
    int lat; logic [2*W-1:0] p; bit bok, tmo; logic da; int d0;
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      run_mul(ta[i], tbv[i], -1, lat, p, bok, tmo, da);
      checks++;
      if (tmo || p !== 16'(ta[i] * tbv[i]) || lat != model_latency(tbv[i])) begin
        errors++;
        $display("FAIL directed %0d*%0d: product=%0d lat=%0d, want %0d lat=%0d",
                 ta[i], tbv[i], p, lat, ta[i] * tbv[i], model_latency(tbv[i]));
      end
      checks++;
      if (!bok || da !== 1'b0 || done_cnt != d0 + 1) begin
        errors++;
        $display("FAIL directed_ctrl %0d: busy_ok=%0b done_after=%b dones=%0d, want 1 0 1",
                 i, bok, da, done_cnt - d0);
      end
    end
  endtask

  task automatic test_early_term;
    logic [W-1:0] aa;
    int lat; logic [2*W-1:0] p; bit bok, tmo; logic da;
    aa = W'($urandom);
    run_mul(aa, 8'd1, -1, lat, p, bok, tmo, da);
    checks++;
`ifdef MUL_EARLY_TERM_EN
    if (lat != 1 || p !== 16'(aa)) begin
`else
    if (lat != W || p !== 16'(aa)) begin
`endif
      errors++;
      $display("FAIL early_b1: lat=%0d product=%0d, want product %0d", lat, p, aa);
    end
    run_mul(8'd0, 8'd0, -1, lat, p, bok, tmo, da);
    checks++;
    if (lat != model_latency(8'd0) || p !== '0) begin
      errors++;
      $display("FAIL early_b0: lat=%0d product=%0d, want lat=%0d product 0", lat, p, model_latency(8'd0));
    end
  endtask

  task automatic test_start_while_busy;
    int lat; logic [2*W-1:0] p; bit bok, tmo; logic da; int d0;
    d0 = done_cnt;
    run_mul(8'd7, 8'd9, 3, lat, p, bok, tmo, da);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (tmo || p !== 16'd63 || lat != model_latency(8'd9) || done_cnt != d0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_while_busy: product=%0d lat=%0d dones=%0d busy=%b, want 63 lat=%0d 1 0",
               p, lat, done_cnt - d0, busy, model_latency(8'd9));
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic [2*W-1:0] p; bit bok, tmo; logic da; int d0;
    start = 1'b1; a = 8'd7; b = 8'd200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b product=%0d, want 0 0 0", busy, done, product);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL reset_mid_lost: dones=%0d, want 0", done_cnt - d0);
    end
    run_mul(8'd3, 8'd5, -1, lat, p, bok, tmo, da);
    checks++;
    if (tmo || p !== 16'd15) begin
      errors++;
      $display("FAIL reset_mid_fresh: product=%0d, want 15", p);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [2*W-1:0] p1, p2; bit bok, tmo1, tmo2; logic da; int d0; logic idle_busy;
    d0 = done_cnt;
    run_mul(8'd20, 8'd12, -1, lat, p1, bok, tmo1, da);
    idle_busy = busy;
    run_mul(8'd6, 8'd6, -1, lat, p2, bok, tmo2, da);
    checks++;
    if (tmo1 || tmo2 || p1 !== 16'd240 || p2 !== 16'd36 || idle_busy !== 1'b0 || done_cnt != d0 + 2) begin
      errors++;
      $display("FAIL back_to_back: products=%0d,%0d busy_gap=%b dones=%0d, want 240,36 0 2",
               p1, p2, idle_busy, done_cnt - d0);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] aa, bb;
    int lat; logic [2*W-1:0] p; bit bok, tmo; logic da;
    for (int i = 0; i < 40; i++) begin
      aa = W'($urandom);
      bb = (i % 4 == 0) ? W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
      run_mul(aa, bb, -1, lat, p, bok, tmo, da);
      checks++;
      if (tmo || p !== 16'(aa * bb) || lat != model_latency(bb) || !bok || da !== 1'b0) begin
        errors++;
        $display("FAIL random %0d*%0d: product=%0d lat=%0d busy_ok=%0b, want %0d lat=%0d",
                 aa, bb, p, lat, bok, aa * bb, model_latency(bb));
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_early_term;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
